// File: rtl/axi_stream_frame_mux.sv
// N-input AXI4-Stream video selector. Source changes only at SOF, so the downstream
// frame writer never sees a torn frame. One registered output stage, drop/frame counters.
module axi_stream_frame_mux #(
    parameter int DW       = 32,
    parameter int NUM_IN   = 4,
    parameter int SEL_W    = $clog2(NUM_IN),
    parameter int DRAIN_EN = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 axi_clk_i,
    input  logic                 axi_rstn_i,
    input  logic [NUM_IN*DW-1:0] s_tdata_i,
    input  logic [NUM_IN-1:0]    s_tvalid_i,
    output logic [NUM_IN-1:0]    s_tready_o,
    input  logic [NUM_IN-1:0]    s_tlast_i,
    input  logic [NUM_IN-1:0]    s_tuser_i,
    output logic [DW-1:0]        m_tdata_o,
    output logic                 m_tvalid_o,
    input  logic                 m_tready_i,
    output logic                 m_tlast_o,
    output logic                 m_tuser_o,
    input  logic [SEL_W-1:0]     sel_i,
    output logic [SEL_W-1:0]     active_o,
    output logic                 sync_o,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o,
    input  logic                 cnt_clr_i
);
    typedef enum logic {ST_SYNC = 1'b0, ST_PASS = 1'b1} state_t;

    localparam logic             DRAIN    = (DRAIN_EN != 0);
    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_req;
    logic [SEL_W-1:0]   r_active;
    logic [SEL_W-1:0]   w_active_nxt;
    logic [DW-1:0]      r_m_tdata;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic               r_m_tuser;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [DW-1:0]      w_data [NUM_IN];
    logic [NUM_IN-1:0]  w_drop_vec;
    logic               w_load;
    logic               w_act_valid;
    logic               w_act_user;
    logic               w_act_last;
    logic [DW-1:0]      w_act_data;
    logic               w_act_rdy;
    logic               w_act_drop;
    logic               w_fwd;
    logic               w_sel_ok;
    logic [CNT_W:0]     w_drop_sum;
    logic [CNT_W:0]     w_drop_ext;
    logic [CNT_W-1:0]   w_drop_nxt;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        logic w_is_act;
        assign w_is_act       = (r_active == SEL_W'(k));
        assign w_data[k]      = s_tdata_i[k*DW +: DW];
        assign s_tready_o[k]  = w_is_act ? w_act_rdy : DRAIN;
        assign w_drop_vec[k]  = w_is_act ? w_act_drop : (DRAIN && s_tvalid_i[k]);
    end

    assign w_load      = !r_m_tvalid || m_tready_i;
    assign w_act_valid = s_tvalid_i[r_active];
    assign w_act_user  = s_tuser_i[r_active];
    assign w_act_last  = s_tlast_i[r_active];
    assign w_act_data  = w_data[r_active];
    assign w_sel_ok    = ({1'b0, sel_i} < NUM_IN_W);

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_act_rdy    = 1'b0;
        w_act_drop   = 1'b0;
        w_fwd        = 1'b0;
        unique case (r_state)
            ST_PASS: begin
                // A pending SOF on a stale source is held back; it becomes the new frame's
                // first beat only if the request flips back before it is consumed.
                if (w_act_user && (r_req != r_active)) begin
                    if (w_act_valid) begin
                        w_state_nxt  = ST_SYNC;
                        w_active_nxt = r_req;
                    end
                end else begin
                    w_act_rdy = w_load;
                    w_fwd     = w_act_valid && w_load;
                end
            end
            ST_SYNC: begin
                if (r_req != r_active) begin
                    w_active_nxt = r_req;
                end else if (!w_act_user) begin
                    w_act_rdy  = 1'b1;
                    w_act_drop = w_act_valid;
                end else begin
                    w_act_rdy = w_load;
                    w_fwd     = w_act_valid && w_load;
                    if (w_fwd) w_state_nxt = ST_PASS;
                end
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    always_comb begin
        w_drop_sum = '0;
        for (int k = 0; k < NUM_IN; k++)
            w_drop_sum = w_drop_sum + (CNT_W+1)'(w_drop_vec[k]);
        w_drop_ext = {1'b0, r_drop_cnt} + w_drop_sum;
        w_drop_nxt = w_drop_ext[CNT_W] ? '1 : w_drop_ext[CNT_W-1:0];
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            r_state  <= ST_SYNC;
            r_active <= '0;
            r_req    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            if (w_sel_ok) r_req <= sel_i;
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= w_fwd;
            if (w_fwd) begin
                r_m_tdata <= w_act_data;
                r_m_tlast <= w_act_last;
                r_m_tuser <= w_act_user;
            end
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (cnt_clr_i) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_m_tvalid && m_tready_i && r_m_tuser) r_frame_cnt <= r_frame_cnt + 1'b1;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    assign m_tdata_o   = r_m_tdata;
    assign m_tvalid_o  = r_m_tvalid;
    assign m_tlast_o   = r_m_tlast;
    assign m_tuser_o   = r_m_tuser;
    assign active_o    = r_active;
    assign sync_o      = (r_state == ST_SYNC);
    assign frame_cnt_o = r_frame_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_axi_stream_frame_mux.sv
// Directed bench for axi_stream_frame_mux: a 4-input draining instance and a
// 5-input non-draining instance share the same stimulus.
module tb_axi_stream_frame_mux;
    typedef struct {
        logic        vld, usr, lst;
        logic [31:0] dat;
        logic        e_rdy, e_mvld, e_musr, e_mlst;
        logic [31:0] e_mdat;
        logic        e_sync;
        logic [15:0] e_drop;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] s_tdata = '0;
    logic [3:0]   s_tvalid = '0, s_tlast = '0, s_tuser = '0;
    logic         m_tready = 1'b1;
    logic [2:0]   sel = '0;
    logic         cnt_clr = 1'b0;

    logic [3:0]  a_tready;
    logic [31:0] a_mdata;
    logic        a_mvalid, a_mlast, a_muser, a_sync;
    logic [1:0]  a_active;
    logic [15:0] a_frame, a_drop;

    logic [4:0]  b_tready;
    logic [31:0] b_mdata;
    logic        b_mvalid, b_mlast, b_muser, b_sync;
    logic [2:0]  b_active;
    logic [15:0] b_frame, b_drop;

    axi_stream_frame_mux #(.DW(32), .NUM_IN(4), .DRAIN_EN(1), .CNT_W(16)) u_dut_a (
        .axi_clk_i(clk), .axi_rstn_i(rstn),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(a_tready),
        .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
        .m_tdata_o(a_mdata), .m_tvalid_o(a_mvalid), .m_tready_i(m_tready),
        .m_tlast_o(a_mlast), .m_tuser_o(a_muser),
        .sel_i(sel[1:0]), .active_o(a_active), .sync_o(a_sync),
        .frame_cnt_o(a_frame), .drop_cnt_o(a_drop), .cnt_clr_i(cnt_clr)
    );

    axi_stream_frame_mux #(.DW(32), .NUM_IN(5), .DRAIN_EN(0), .CNT_W(16)) u_dut_b (
        .axi_clk_i(clk), .axi_rstn_i(rstn),
        .s_tdata_i({32'h0, s_tdata}), .s_tvalid_i({1'b0, s_tvalid}), .s_tready_o(b_tready),
        .s_tlast_i({1'b0, s_tlast}), .s_tuser_i({1'b0, s_tuser}),
        .m_tdata_o(b_mdata), .m_tvalid_o(b_mvalid), .m_tready_i(m_tready),
        .m_tlast_o(b_mlast), .m_tuser_o(b_muser),
        .sel_i(sel), .active_o(b_active), .sync_o(b_sync),
        .frame_cnt_o(b_frame), .drop_cnt_o(b_drop), .cnt_clr_i(cnt_clr)
    );

    int          n_chk = 0, n_pass = 0, stab_err = 0;
    logic [33:0] srcq [4][$];
    logic [33:0] outq [$];
    logic [3:0]  flood = '0;
    logic        rand_rdy = 1'b0, rdy_fix = 1'b1, prev_stall = 1'b0;
    logic [34:0] prev_m = '0;
    vec_t        tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [33:0] beat(input logic [31:0] base, input int i);
        return {(i == 0), (i % 4 == 3), base + 32'(i)};
    endfunction

    task automatic push_frame(input int k, input logic [31:0] base);
        for (int i = 0; i < 8; i++) srcq[k].push_back(beat(base, i));
    endtask

    // Present queue fronts on the falling edge and settle; outputs are sampled after this.
    task automatic drive();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (flood[k]) begin
                s_tvalid[k] = 1'b1; s_tuser[k] = 1'b0; s_tlast[k] = 1'b0;
                s_tdata[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            end else if (srcq[k].size() > 0) begin
                s_tvalid[k] = 1'b1;
                {s_tuser[k], s_tlast[k], s_tdata[k*32 +: 32]} = srcq[k][0];
            end else begin
                s_tvalid[k] = 1'b0; s_tuser[k] = 1'b0; s_tlast[k] = 1'b0;
                s_tdata[k*32 +: 32] = '0;
            end
        end
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
        #1;
    endtask

    task automatic finish();
        if (prev_stall && ({a_mvalid, a_muser, a_mlast, a_mdata} !== prev_m)) stab_err++;
        prev_stall = a_mvalid && !m_tready;
        prev_m     = {a_mvalid, a_muser, a_mlast, a_mdata};
        if (a_mvalid && m_tready) outq.push_back({a_muser, a_mlast, a_mdata});
        for (int k = 0; k < 4; k++)
            if (!flood[k] && s_tvalid[k] && a_tready[k]) void'(srcq[k].pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        drive();
        finish();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flood = '0; sel = '0; cnt_clr = 1'b0; rand_rdy = 1'b0; rdy_fix = 1'b1;
        for (int k = 0; k < 4; k++) srcq[k].delete();
        s_tvalid = '0; s_tuser = '0; s_tlast = '0; s_tdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        prev_stall = 1'b0;
        outq.delete();
    endtask

    task automatic chk_frame(input string name, input int off, input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.beat%0d", name, i),
                32'((off + i < outq.size()) ? outq[off + i] : 34'h0),
                32'(beat(base, i)));
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.side%0d", name, i),
                32'((off + i < outq.size()) ? outq[off + i][33:32] : 2'h0),
                32'(beat(base, i) >> 32));
    endtask

    initial begin
        // step n presents record n on input 0; m_* shows record n-1 (one-cycle latency)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0F0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0F1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 16'd1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0F2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 16'd2};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0F3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 16'd3};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 16'd4};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h101, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 16'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h102, 1'b1, 1'b1, 1'b0, 1'b0, 32'h101, 1'b0, 16'd4};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102, 1'b0, 16'd4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 1'b0, 16'd4};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h105, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 16'd4};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h106, 1'b1, 1'b1, 1'b0, 1'b0, 32'h105, 1'b0, 16'd4};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h107, 1'b1, 1'b1, 1'b0, 1'b0, 32'h106, 1'b0, 16'd4};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h107, 1'b0, 16'd4};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 16'd4};

        // reset state
        do_reset();
        chk("rst.mvalid", 32'(a_mvalid), 32'd0);
        chk("rst.mdata",  a_mdata, 32'd0);
        chk("rst.sync",   32'(a_sync), 32'd1);
        chk("rst.active", 32'(a_active), 32'd0);
        chk("rst.frame",  32'(a_frame), 32'd0);
        chk("rst.drop",   32'(a_drop), 32'd0);
        chk("rst.a_rdy",  32'(a_tready), 32'hF);
        chk("rst.b_rdy",  32'(b_tready), 32'h01);

        // pre-SOF drops, then one frame out with one-cycle latency
        for (int n = 0; n < 14; n++) begin
            if (tbl[n].vld) srcq[0].push_back({tbl[n].usr, tbl[n].lst, tbl[n].dat});
            drive();
            chk($sformatf("t1.rdy[%0d]", n), 32'(a_tready[0]), 32'(tbl[n].e_rdy));
            chk($sformatf("t1.mvld[%0d]", n), 32'(a_mvalid), 32'(tbl[n].e_mvld));
            if (tbl[n].e_mvld) begin
                chk($sformatf("t1.mdat[%0d]", n), a_mdata, tbl[n].e_mdat);
                chk($sformatf("t1.mside[%0d]", n), 32'({a_muser, a_mlast}),
                    32'({tbl[n].e_musr, tbl[n].e_mlst}));
            end
            chk($sformatf("t1.sync[%0d]", n), 32'(a_sync), 32'(tbl[n].e_sync));
            chk($sformatf("t1.drop[%0d]", n), 32'(a_drop), 32'(tbl[n].e_drop));
            finish();
        end
        chk("t1.frame", 32'(a_frame), 32'd1);

        // counter clear, then switch 0 -> 2 at beat 3
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("clr.frame", 32'(a_frame), 32'd0);
        chk("clr.drop",  32'(a_drop), 32'd0);
        outq.delete();
        push_frame(0, 32'h200);
        push_frame(0, 32'h300);
        for (int i = 0; i < 12; i++) srcq[2].push_back({2'b00, 32'h2F00 + 32'(i)});
        push_frame(2, 32'h2200);
        repeat (3) step();
        sel = 3'd2;
        repeat (30) step();
        chk("t2.q0_empty", 32'(srcq[0].size()), 32'd0);
        chk("t2.q2_empty", 32'(srcq[2].size()), 32'd0);
        chk("t2.nout", 32'(outq.size()), 32'd16);
        chk_frame("t2.f0", 0, 32'h200);
        chk_frame("t2.f2", 8, 32'h2200);
        chk("t2.drop",   32'(a_drop), 32'd20);
        chk("t2.frame",  32'(a_frame), 32'd2);
        chk("t2.active", 32'(a_active), 32'd2);
        chk("t2.sync",   32'(a_sync), 32'd0);

        // request toggles 0 -> 1 -> 0 inside a frame: no switch
        begin
            int act_err = 0, sync_err = 0;
            do_reset();
            push_frame(0, 32'h400);
            push_frame(0, 32'h500);
            for (int s = 0; s < 25; s++) begin
                if (s == 2) sel = 3'd1;
                if (s == 4) sel = 3'd0;
                drive();
                if (a_active != 2'd0) act_err++;
                if (s >= 1 && a_sync) sync_err++;
                finish();
            end
            chk("t3.active_err", 32'(act_err), 32'd0);
            chk("t3.sync_err", 32'(sync_err), 32'd0);
            chk("t3.nout", 32'(outq.size()), 32'd16);
            chk_frame("t3.f4", 0, 32'h400);
            chk_frame("t3.f5", 8, 32'h500);
            chk("t3.frame", 32'(a_frame), 32'd2);
        end

        // 1000 beats under random back-pressure
        begin
            int bad = 0;
            do_reset();
            for (int i = 0; i < 1000; i++)
                srcq[0].push_back({(i % 8 == 0), (i % 4 == 3), 32'h1_0000 + 32'(i)});
            rand_rdy = 1'b1;
            stab_err = 0;
            for (int s = 0; s < 6000 && outq.size() < 1000; s++) step();
            rand_rdy = 1'b0;
            chk("t4.nout", 32'(outq.size()), 32'd1000);
            for (int i = 0; i < 1000 && i < outq.size(); i++)
                if (outq[i] !== {(i % 8 == 0), (i % 4 == 3), 32'h1_0000 + 32'(i)}) begin
                    if (bad == 0) $display("FAIL t4.beat%0d: got %h, expected %h", i, outq[i],
                        {(i % 8 == 0), (i % 4 == 3), 32'h1_0000 + 32'(i)});
                    bad++;
                end
            n_chk++;
            if (bad == 0) n_pass++;
            chk("t4.stable_err", 32'(stab_err), 32'd0);
            chk("t4.frame", 32'(a_frame), 32'd125);
        end

        // draining vs non-draining unselected inputs, then clear priority
        begin
            int a_err = 0, b_err = 0;
            do_reset();
            flood = 4'b1010;
            for (int s = 0; s < 100; s++) begin
                drive();
                if (a_tready[1] !== 1'b1 || a_tready[3] !== 1'b1) a_err++;
                if (b_tready[1] !== 1'b0 || b_tready[3] !== 1'b0) b_err++;
                finish();
            end
            chk("t5.a_rdy_err", 32'(a_err), 32'd0);
            chk("t5.b_rdy_err", 32'(b_err), 32'd0);
            chk("t5.a_drop", 32'(a_drop), 32'd200);
            chk("t5.b_drop", 32'(b_drop), 32'd0);
            cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
            chk("t5.clr_prio", 32'(a_drop), 32'd0);
            step();
            chk("t5.after_clr", 32'(a_drop), 32'd2);
        end

        // drop counter saturation: four drops per cycle
        do_reset();
        flood = 4'b1111;
        repeat (16383) step();
        chk("sat.pre", 32'(a_drop), 32'd65532);
        repeat (10) step();
        chk("sat.hold", 32'(a_drop), 32'hFFFF);

        // asynchronous reset mid-frame with a stalled output beat
        do_reset();
        for (int i = 0; i < 3; i++) srcq[2].push_back({2'b00, 32'h2E00 + 32'(i)});
        push_frame(0, 32'h600);
        repeat (4) step();
        rdy_fix = 1'b0;
        repeat (2) step();
        chk("t6.pre_mvalid", 32'(a_mvalid), 32'd1);
        chk("t6.pre_frame", 32'(a_frame), 32'd1);
        chk("t6.pre_drop", 32'(a_drop), 32'd3);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        for (int k = 0; k < 4; k++) srcq[k].delete();
        s_tvalid = '0; s_tuser = '0; s_tlast = '0;
        #1;
        chk("t6.async_mvalid", 32'(a_mvalid), 32'd0);
        chk("t6.async_mdata", a_mdata, 32'd0);
        chk("t6.async_active", 32'(a_active), 32'd0);
        chk("t6.async_sync", 32'(a_sync), 32'd1);
        chk("t6.async_frame", 32'(a_frame), 32'd0);
        chk("t6.async_drop", 32'(a_drop), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rdy_fix = 1'b1;
        prev_stall = 1'b0;
        step();
        chk("t6.post_sync", 32'(a_sync), 32'd1);
        chk("t6.post_active", 32'(a_active), 32'd0);

        // out-of-range select on the 5-input instance
        sel = 3'd5;
        repeat (3) step();
        chk("sel.5_ignored", 32'(b_active), 32'd0);
        sel = 3'd2;
        repeat (3) step();
        chk("sel.2_follow", 32'(b_active), 32'd2);
        chk("sel.2_sync", 32'(b_sync), 32'd1);
        sel = 3'd7;
        repeat (3) step();
        chk("sel.7_ignored", 32'(b_active), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
